// File: rtl/uart_tx.sv
// UART transmitter: 8N1/8N2 framing, LSB first, fixed CLKS_PER_BIT, registered serial output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit(s).
module uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_tx_data,
  input  logic       in_tx_en,
  output logic       out_serial,
  output logic       out_tx_busy,
  output logic       out_tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP} state_t;
  logic parity_q, parity_d;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_GAP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    shift_q, shift_d;
  logic          serial_q, serial_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;
  logic          accept;

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = '0;
    gap_d   = '0;
    shift_d = shift_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_tx_en) begin
          state_d = S_START;
          accept  = 1'b1;
        end
      end
      S_START: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        bit_d = bit_end ? bit_q + 3'd1 : bit_q;
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          if (bit_q == STOP_LAST) state_d = S_GAP;
          else bit_d = bit_q + 3'd1;
        end else begin
          bit_d = bit_q;
        end
      end
      S_GAP: begin
        // The closing GAP edge doubles as an idle edge, so held-enable frames sit exactly GAP_CYCLES apart.
        if (gap_q == GAP_LAST) begin
          if (in_tx_en) begin
            state_d = S_START;
            accept  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) shift_d = in_tx_data;
`ifdef UART_TX_PARITY_EN
    parity_d = accept ? ^in_tx_data : parity_q;
`endif
  end

  // Outputs are decoded from the next state so the registered line moves on the same edge as the FSM.
  always_comb begin
    serial_d = 1'b1;
    busy_d   = 1'b0;
    done_d   = (state_d == S_GAP) && (state_q != S_GAP);
    case (state_d)
      S_START: begin
        serial_d = 1'b0;
        busy_d   = 1'b1;
      end
      S_DATA: begin
        serial_d = shift_d[0];
        busy_d   = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        serial_d = parity_d;
        busy_d   = 1'b1;
      end
`endif
      S_STOP:  busy_d = 1'b1;
      default: serial_d = 1'b1;
    endcase
  end

  assign out_serial  = serial_q;
  assign out_tx_busy = busy_q;
  assign out_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, single frames, back-to-back, mid-frame reset, hello-message stream.
// Build with UART_TX_PARITY_EN defined to exercise the parity framing.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int NSTOP = 1;
  localparam int GAP   = 2;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME_BITS = 1 + 8 + PBITS + NSTOP;
  localparam int FRAME_CYC  = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_en = 1'b0;
  logic       serial, busy, done;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(NSTOP), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_tx_data (tx_data),
    .in_tx_en   (tx_en),
    .out_serial (serial),
    .out_tx_busy(busy),
    .out_tx_done(done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Bench-side receiver: samples mid-bit on falling clock edges and queues each decoded byte.
  logic [7:0] dec_q[$];
  logic       dec_act = 1'b0;
  int         dec_cnt = 0;
  logic [7:0] dec_sh = 8'h00;
  logic       dec_par = 1'b0;
  int         dec_bad = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      dec_act <= 1'b0;
      dec_cnt <= 0;
    end else if (!dec_act) begin
      if (serial === 1'b0) begin
        dec_act <= 1'b1;
        dec_cnt <= 1;
      end
    end else begin
      dec_cnt <= dec_cnt + 1;
      if ((dec_cnt % CPB) == 2 && (dec_cnt / CPB) >= 1 && (dec_cnt / CPB) <= 8)
        dec_sh[(dec_cnt / CPB) - 1] <= serial;
      if (PBITS == 1 && dec_cnt == 9 * CPB + 2)
        dec_par <= serial;
      if (dec_cnt == (1 + 8 + PBITS) * CPB + 2) begin
        if (serial !== 1'b1 || (PBITS == 1 && dec_par !== ^dec_sh)) dec_bad <= dec_bad + 1;
        dec_q.push_back(dec_sh);
        $display("rx byte 0x%02h", dec_sh);
        dec_act <= 1'b0;
      end
    end
  end

  logic cap_ser  [0:199];
  logic cap_busy [0:199];
  logic cap_done [0:199];

  task automatic start_send(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_en   = 1'b1;
    $display("tx byte 0x%02h", d);
  endtask

  task automatic capture(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cap_ser[c]  = serial;
      cap_busy[c] = busy;
      cap_done[c] = done;
      if (c == 0) tx_en = 1'b0;
    end
  endtask

  // Checks one captured frame starting at sample 'off' (first sample after the accepting edge).
  task automatic check_frame(input string tag, input logic [7:0] d, input logic par, input int off);
    logic exp_bit;
    int   nb;
    for (int k = 0; k < FRAME_BITS; k++) begin
      if (k == 0) exp_bit = 1'b0;
      else if (k <= 8) exp_bit = d[k-1];
      else if (PBITS == 1 && k == 9) exp_bit = par;
      else exp_bit = 1'b1;
      check($sformatf("%s bit%0d", tag, k), 32'(cap_ser[off + k*CPB + 2]), 32'(exp_bit));
    end
    nb = 0;
    for (int c = off; c < off + FRAME_CYC; c++) if (cap_busy[c] === 1'b1) nb++;
    check({tag, " busy_cycles"}, nb, FRAME_CYC);
    check({tag, " busy_fall"}, 32'(cap_busy[off + FRAME_CYC]), 0);
    check({tag, " done_pulse"}, 32'(cap_done[off + FRAME_CYC]), 1);
    check({tag, " done_end"}, 32'(cap_done[off + FRAME_CYC + 1]), 0);
    check({tag, " line_after"}, 32'(cap_ser[off + FRAME_CYC]), 1);
  endtask

  logic [7:0] msg [0:7] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21, 8'h21, 8'h0A};

  initial begin
    int cnt;
    int idx;
    logic pend, prev;
    int sent_frames;

    // Reset and idle line
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst serial", 32'(serial), 1);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (serial !== 1'b1 || busy !== 1'b0) cnt++;
    end
    check("idle line", cnt, 0);

    // Single frames
    start_send(8'h48);
    capture(60);
    check_frame("b48", 8'h48, 1'b0, 0);
    cnt = 0;
    for (int c = 0; c < 60; c++) if (cap_done[c] === 1'b1) cnt++;
    check("b48 done_count", cnt, 1);
    check("b48 first_low", 32'(cap_ser[0]), 0);

    start_send(8'h07);
    capture(60);
    check_frame("b07", 8'h07, 1'b1, 0);

    // Back-to-back with enable held; data advances one edge after busy falls
    dec_q.delete();
    start_send(8'h65);
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      cap_ser[c]  = serial;
      cap_busy[c] = busy;
      cap_done[c] = done;
      if (c == FRAME_CYC + 1) tx_data = 8'h6C;
      if (c == FRAME_CYC + GAP) tx_en = 1'b0;
    end
    $display("tx byte 0x6c");
    check_frame("b2b0", 8'h65, 1'b0, 0);
    check_frame("b2b1", 8'h6C, 1'b0, FRAME_CYC + GAP);
    cnt = 0;
    for (int c = 0; c < 2 * FRAME_CYC + GAP; c++) if (cap_busy[c] === 1'b0 && cap_ser[c] === 1'b1) cnt++;
    check("b2b gap_cycles", cnt, GAP);
    check("b2b frames", dec_q.size(), 2);
    check("b2b byte0", 32'(dec_q[0]), 32'h65);
    check("b2b byte1", 32'(dec_q[1]), 32'h6C);

    // Reset during data bit 3 of 0xFF
    start_send(8'hFF);
    capture(18);
    check("mid bit3 live", 32'({cap_busy[17], cap_ser[17]}), 32'h3);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid rst serial", 32'(serial), 1);
    check("mid rst busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("mid idle", 32'({busy, serial}), 32'h1);
    dec_q.delete();
    start_send(8'h21);
    capture(60);
    check_frame("b21", 8'h21, 1'b0, 0);
    check("b21 frames", dec_q.size(), 1);
    check("b21 byte", 32'(dec_q[0]), 32'h21);

    // Hello-message producer: holds enable, advances one edge after observing busy fall
    dec_q.delete();
    idx = 0;
    pend = 1'b0;
    prev = 1'b0;
    sent_frames = -1;
    @(negedge clk);
    tx_data = msg[0];
    tx_en = 1'b1;
    for (int c = 0; c < 8 * (FRAME_CYC + GAP) + 100; c++) begin
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        idx++;
        if (idx < 8) tx_data = msg[idx];
        else begin
          tx_en = 1'b0;
          sent_frames = dec_q.size();
        end
      end
      if (prev && !busy) pend = 1'b1;
      prev = busy;
    end
    check("hello message_sent", 32'(idx == 8), 1);
    check("hello frames_at_sent", sent_frames, 8);
    check("hello frames_total", dec_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < dec_q.size()) check($sformatf("hello byte%0d", i), 32'(dec_q[i]), 32'(msg[i]));
    check("decoder framing errors", dec_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
